dff_response_checker: RTL and testbench

//  Self-checking monitor at the far end of the D-FF stimulus path: samples the

---
 rtl/dff_response_checker.sv | 105 ++++++++++
 tb/tb_dff_response_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Response checker for the D-FF stimulus path.
// Predicts q from d delayed LATENCY cycles; counts compares and mismatches.
module dff_response_checker #(
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             q,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic [1:0]       state,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    CHECK = 2'b10,
    HALT  = 2'b11
  } st_t;

  localparam logic [3:0] FILL_LAST = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  st_t                st;
  logic [LATENCY-1:0] exp_q;
  logic [LATENCY-1:0] exp_nxt;
  logic [LATENCY:0]   shift_w;
  logic [3:0]         fill;
  logic               miss;
  logic [CNT_W-1:0]   chk_inc;
  logic [CNT_W-1:0]   err_inc;

  assign state = st;

  // Next pipe value, mismatch detect and saturating increments.
  always_comb begin
    shift_w = {exp_q, d};
    exp_nxt = shift_w[LATENCY-1:0];
    miss    = q ^ exp_q[LATENCY-1];
    chk_inc = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + 1'b1;
    err_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
  end

  // Control FSM with pipe, counters and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      exp_q     <= '0;
      fill      <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= '0;
      halted    <= 1'b0;
    end else if (clr) begin
      st        <= IDLE;
      exp_q     <= '0;
      fill      <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      first_err <= '0;
      halted    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (en && st != HALT) begin
        exp_q <= exp_nxt;
        unique case (st)
          IDLE: begin
            fill <= 4'd1;
            st   <= (LATENCY == 1) ? CHECK : FILL;
          end
          FILL: begin
            fill <= fill + 4'd1;
            if (fill == FILL_LAST)
              st <= CHECK;
          end
          CHECK: begin
            chk_cnt <= chk_inc;
            if (miss) begin
              err     <= 1'b1;
              err_cnt <= err_inc;
              if (err_cnt == '0)
                first_err <= chk_cnt;
              if (STOP_ON_ERR) begin
                st     <= HALT;
                halted <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker.
// Three instances: L1 free-running, L1 stop-on-error, L3 with 4-bit counters.
module tb_dff_response_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic en1 = 1'b0;
  logic clr1 = 1'b0;
  logic d1 = 1'b0;
  logic inv1 = 1'b0;
  logic qff = 1'b0;
  logic q1;
  assign q1 = qff ^ inv1;

  logic en3 = 1'b0;
  logic clr3 = 1'b0;
  logic d3 = 1'b0;
  logic q3 = 1'b0;

  logic        err1, halted1, err2, halted2, err3, halted3;
  logic [15:0] ecnt1, chk1, fe1, ecnt2, chk2, fe2;
  logic [3:0]  ecnt3, chk3, fe3;
  logic [1:0]  st1, st2, st3;

  int errors = 0;
  int checks = 0;

  dff_response_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en1), .clr(clr1), .d(d1), .q(q1),
    .err(err1), .err_cnt(ecnt1), .chk_cnt(chk1), .first_err(fe1),
    .state(st1), .halted(halted1)
  );

  dff_response_checker #(.LATENCY(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en1), .clr(clr1), .d(d1), .q(q1),
    .err(err2), .err_cnt(ecnt2), .chk_cnt(chk2), .first_err(fe2),
    .state(st2), .halted(halted2)
  );

  dff_response_checker #(.LATENCY(3), .CNT_W(4), .STOP_ON_ERR(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en3), .clr(clr3), .d(d3), .q(q3),
    .err(err3), .err_cnt(ecnt3), .chk_cnt(chk3), .first_err(fe3),
    .state(st3), .halted(halted3)
  );

  always #50 clk = ~clk;

  // Ideal D flip-flop feeding the L1 instances.
  always @(posedge clk) qff <= d1;

  typedef struct {
    logic en, clr, d, q, err;
    int   chk, ecnt, fe, st;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int i);
    return logic'(((i * 100) / 70) % 2);
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, 2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 0, 2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1, 2, 2};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1, 2, 2};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 2, 2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 2, 2, 2};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por st1", int'(st1), 0);
    check("por chk1", int'(chk1), 0);
    check("por err1", int'(err1), 0);
    check("por st3", int'(st3), 0);
    check("por halted2", int'(halted2), 0);
    rst = 1'b0;

    // Ideal DFF, 20 enabled edges, no mismatches.
    for (int i = 1; i <= 20; i++) begin
      d1  = pat(i);
      en1 = 1'b1;
      tick();
      check("t2 err1", int'(err1), 0);
      check("t2 err2", int'(err2), 0);
    end
    en1 = 1'b0;
    check("t2 chk1", int'(chk1), 19);
    check("t2 ecnt1", int'(ecnt1), 0);
    check("t2 st1", int'(st1), 2);
    check("t2 chk2", int'(chk2), 19);

    // Asynchronous reset in CHECK with nonzero counts.
    #20 rst = 1'b1;
    #1;
    check("arst st1", int'(st1), 0);
    check("arst chk1", int'(chk1), 0);
    check("arst ecnt1", int'(ecnt1), 0);
    check("arst fe1", int'(fe1), 0);
    check("arst err1", int'(err1), 0);
    check("arst chk2", int'(chk2), 0);
    check("arst halted2", int'(halted2), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single inverted q at compare index 4; u2 halts there.
    for (int i = 1; i <= 20; i++) begin
      d1   = pat(i);
      en1  = 1'b1;
      inv1 = (i == 6);
      tick();
      check("t3 err1", int'(err1), int'(i == 6));
      check("t4 err2", int'(err2), int'(i == 6));
      if (i >= 6) begin
        check("t4 st2", int'(st2), 3);
        check("t4 halted2", int'(halted2), 1);
        check("t4 chk2", int'(chk2), 5);
      end
    end
    inv1 = 1'b0;
    check("t3 ecnt1", int'(ecnt1), 1);
    check("t3 fe1", int'(fe1), 4);
    check("t3 chk1", int'(chk1), 19);
    check("t4 ecnt2", int'(ecnt2), 1);
    check("t4 fe2", int'(fe2), 4);

    // Clear overrides en and leaves HALT.
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    en1  = 1'b0;
    check("clr st2", int'(st2), 0);
    check("clr halted2", int'(halted2), 0);
    check("clr chk2", int'(chk2), 0);
    check("clr ecnt2", int'(ecnt2), 0);
    check("clr fe2", int'(fe2), 0);
    check("clr st1", int'(st1), 0);
    check("clr chk1", int'(chk1), 0);

    // LATENCY=3 table: fill, en gaps, mismatches, clr.
    for (int r = 0; r < 17; r++) begin
      en3  = tbl[r].en;
      clr3 = tbl[r].clr;
      d3   = tbl[r].d;
      q3   = tbl[r].q;
      tick();
      check($sformatf("t6[%0d] err", r), int'(err3), int'(tbl[r].err));
      check($sformatf("t6[%0d] chk", r), int'(chk3), tbl[r].chk);
      check($sformatf("t6[%0d] ecnt", r), int'(ecnt3), tbl[r].ecnt);
      check($sformatf("t6[%0d] fe", r), int'(fe3), tbl[r].fe);
      check($sformatf("t6[%0d] st", r), int'(st3), tbl[r].st);
    end
    clr3 = 1'b0;

    // Finish filling with zeros, then saturate with q always wrong.
    en3 = 1'b1;
    d3  = 1'b0;
    q3  = 1'b1;
    repeat (2) tick();
    check("t5 fill st3", int'(st3), 2);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t5 err3", int'(err3), 1);
      check("t5 chk3", int'(chk3), sat15(i));
      check("t5 ecnt3", int'(ecnt3), sat15(i));
    end
    check("t5 fe3", int'(fe3), 0);
    check("t5 halted3", int'(halted3), 0);
    en3 = 1'b0;
    tick();
    check("t5 err3 idle", int'(err3), 0);
    check("t5 chk3 hold", int'(chk3), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
